shift_reg_n: RTL

Parametrised parallel-load shift register, the successor to the fixed 8-bit two-nibble register used in the multiplier datapath.
- Generalised to WIDTH bits with four shift modes.
- Adds an autonomous burst mode: a counter-driven FSM performs N consecutive shifts after a single Start, with Busy/Done handshake.
- Serves as the accumulator/operand register for multi-step arithmetic units (shift-add multiplier, divider).

---
 rtl/shift_pkg.sv | 61 ++++++
 rtl/shift_burst_ctrl.sv | 93 +++++++++
 rtl/shift_reg_n.sv | 72 +++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared types and the single-step shift function for the shift_reg_n slice.
//   shift_mode_t : serial shift operation selected by the 2-bit Mode code
//   state_t      : burst controller states
//   shift_one()  : next register value for one shift of a WIDTH-bit value
//                  held in the low bits of a MAX_W-bit vector
package shift_pkg;

    localparam int unsigned MAX_W = 64;

    typedef enum logic [1:0] {
        SM_SRL = 2'b00,
        SM_SRA = 2'b01,
        SM_SL  = 2'b10,
        SM_ROR = 2'b11
    } shift_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    // Width is passed at run time so one package function serves every
    // WIDTH; the MSB position is located by loop compare rather than a
    // variable bit-select so the index stays constant after unrolling.
    function automatic logic [MAX_W-1:0] shift_one(
        input logic [MAX_W-1:0] a,
        input shift_mode_t      mode,
        input logic             sin,
        input int unsigned      width
    );
        logic [MAX_W-1:0] r;
        logic [MAX_W-1:0] mask;
        logic             msb;
        logic             fill;

        mask = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
        msb  = 1'b0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i == width - 1) msb = a[i];
        end

        case (mode)
            SM_SRL:  fill = sin;
            SM_SRA:  fill = msb;
            SM_ROR:  fill = a[0];
            default: fill = 1'b0;
        endcase

        if (mode == SM_SL) begin
            r = (a << 1) | MAX_W'(sin);
        end else begin
            r = (a & mask) >> 1;
            for (int unsigned i = 0; i < MAX_W; i++) begin
                if (i == width - 1) r[i] = fill;
            end
        end
        return r & mask;
    endfunction

endpackage

// File: rtl/shift_burst_ctrl.sv
// Burst controller for shift_reg_n.
// Owns the IDLE/SHIFT/DONE state machine, the remaining-shift counter and
// the mode latched at burst start.
//   clk, rst_n      : clock, asynchronous active-low reset
//   load            : parallel load request (aborts a burst)
//   start, count    : begin a burst of count shifts (IDLE only)
//   shift_en        : single shift request (IDLE only)
//   mode            : live shift mode
//   shift_now       : register shifts on this edge
//   sel_mode        : mode to use for the shift and Shift_Out
//   busy, done      : burst in progress / one-cycle completion pulse
module shift_burst_ctrl
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          start,
    input  logic          shift_en,
    input  logic [CW-1:0] count,
    input  shift_mode_t   mode,
    output logic          shift_now,
    output shift_mode_t   sel_mode,
    output logic          busy,
    output logic          done
);

    state_t        state_q, state_d;
    logic [CW-1:0] rem_q, rem_d;
    shift_mode_t   burst_mode_q, burst_mode_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rem_q        <= '0;
            burst_mode_q <= SM_SRL;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            burst_mode_q <= burst_mode_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        burst_mode_d = burst_mode_q;
        shift_now    = 1'b0;
        sel_mode     = mode;

        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    if (count == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        // Counts beyond WIDTH clamp so rem never exceeds WIDTH.
                        rem_d        = (count > CW'(WIDTH)) ? CW'(WIDTH) : count;
                        burst_mode_d = mode;
                        state_d      = ST_SHIFT;
                    end
                end else if (shift_en) begin
                    shift_now = 1'b1;
                end
            end
            ST_SHIFT: begin
                sel_mode = burst_mode_q;
                if (load) begin
                    state_d = ST_IDLE;
                end else begin
                    shift_now = 1'b1;
                    rem_d     = rem_q - CW'(1);
                    if (rem_q == CW'(1)) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy = (state_q == ST_SHIFT);
    assign done = (state_q == ST_DONE);

endmodule

// File: rtl/shift_reg_n.sv
// Parametrised parallel-load shift register with single-shift and
// autonomous burst operation.
//   Clk       : rising-edge clock
//   Reset     : asynchronous active-low reset
//   Load, D   : parallel load (highest priority)
//   Start     : begin a burst of Count shifts
//   Shift_En  : single shift in IDLE
//   Mode      : 00 SRL, 01 SRA, 10 SL, 11 ROR
//   Shift_In  : serial fill bit for SRL/SL
//   A         : register contents
//   Shift_Out : bit that leaves on the next shift
//   Busy      : burst in progress
//   Done      : one-cycle burst completion pulse
module shift_reg_n
    import shift_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Load,
    input  logic             Shift_En,
    input  logic             Start,
    input  logic [CW-1:0]    Count,
    input  logic [1:0]       Mode,
    input  logic             Shift_In,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] A,
    output logic             Shift_Out,
    output logic             Busy,
    output logic             Done
);

    logic [WIDTH-1:0] a_q, a_d;
    logic             shift_now;
    shift_mode_t      sel_mode;
    logic [MAX_W-1:0] a_shifted;

    shift_burst_ctrl #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_ctrl (
        .clk       (Clk),
        .rst_n     (Reset),
        .load      (Load),
        .start     (Start),
        .shift_en  (Shift_En),
        .count     (Count),
        .mode      (shift_mode_t'(Mode)),
        .shift_now (shift_now),
        .sel_mode  (sel_mode),
        .busy      (Busy),
        .done      (Done)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) a_q <= '0;
        else        a_q <= a_d;
    end

    always_comb begin
        a_shifted = shift_one(MAX_W'(a_q), sel_mode, Shift_In, WIDTH);
        a_d       = a_q;
        if (Load)           a_d = D;
        else if (shift_now) a_d = a_shifted[WIDTH-1:0];
    end

    assign A         = a_q;
    assign Shift_Out = (sel_mode == SM_SL) ? a_q[WIDTH-1] : a_q[0];

endmodule
